// File: rtl/rad_cdc_meta_sync.sv
// Multi-bit metastability synchroniser with optional one-cycle delay injection on stage 0,
// used to expose downstream logic to the extra cycle of latency a real synchroniser can add.
module rad_cdc_meta_sync #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 2,
  parameter logic [31:0] SEED   = 32'hC0FFEE01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_i,
  input  logic [1:0]       inject_mode_i,
  input  logic             cnt_clr_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic [15:0]      inject_cnt_o
);

  // An all-zero Galois LFSR would lock up, so a zero seed is promoted to 1.
  localparam logic [31:0] SeedEff  = (SEED == 32'd0) ? 32'd1 : SEED;
  localparam logic [31:0] LfsrTaps = 32'h8020_0003;

  logic [STAGES-1:0][WIDTH-1:0] stage_q;
  logic [WIDTH-1:0]             stage0_d;
  logic [WIDTH-1:0]             held_q, held_d;
  logic [WIDTH-1:0]             sync_dly_q;
  logic [WIDTH-1:0]             cand, inject;
  logic [31:0]                  lfsr_q, lfsr_d;
  logic [15:0]                  cnt_q, cnt_d;

  always_comb begin
    // held_q blocks back-to-back delays so extra latency never exceeds one cycle.
    cand   = (async_i ^ stage_q[0]) & ~held_q;
    inject = '0;
    unique case (inject_mode_i)
      2'b01:   inject = cand & lfsr_q[WIDTH-1:0];
      2'b10:   inject = cand;
      default: inject = '0;
    endcase

    stage0_d = (stage_q[0] & inject) | (async_i & ~inject);
    held_d   = inject;
    lfsr_d   = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LfsrTaps : 32'd0);

    cnt_d = cnt_q;
    if (cnt_clr_i) begin
      cnt_d = '0;
    end else if ((|inject) && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q    <= '0;
      held_q     <= '0;
      sync_dly_q <= '0;
      lfsr_q     <= SeedEff;
      cnt_q      <= '0;
    end else begin
      stage_q    <= {stage_q[STAGES-2:0], stage0_d};
      held_q     <= held_d;
      sync_dly_q <= stage_q[STAGES-1];
      lfsr_q     <= lfsr_d;
      cnt_q      <= cnt_d;
    end
  end

  assign sync_o       = stage_q[STAGES-1];
  assign rise_o       = sync_o & ~sync_dly_q;
  assign fall_o       = ~sync_o & sync_dly_q;
  assign inject_cnt_o = cnt_q;

endmodule

// File: tb/tb_rad_cdc_meta_sync.sv
// Scoreboard bench for rad_cdc_meta_sync: a behavioural model predicts every cycle's outputs.
module tb_rad_cdc_meta_sync;

  localparam int W = 8;
  localparam int S = 2;
  localparam int NRand = 1000;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] async_i;
  logic [1:0]   mode;
  logic         clr;
  logic [W-1:0] sync_o, rise_o, fall_o;
  logic [15:0]  cnt_o;
  logic [0:0]   z_async, z_sync, z_rise, z_fall;
  logic [15:0]  z_cnt;

  always #5 clk = ~clk;

  rad_cdc_meta_sync #(.WIDTH(W), .STAGES(S)) dut (
    .clk          (clk),
    .rst          (rst),
    .async_i      (async_i),
    .inject_mode_i(mode),
    .cnt_clr_i    (clr),
    .sync_o       (sync_o),
    .rise_o       (rise_o),
    .fall_o       (fall_o),
    .inject_cnt_o (cnt_o)
  );

  rad_cdc_meta_sync #(.WIDTH(1), .STAGES(3), .SEED(32'd0)) dut_z (
    .clk          (clk),
    .rst          (rst),
    .async_i      (z_async),
    .inject_mode_i(mode),
    .cnt_clr_i    (clr),
    .sync_o       (z_sync),
    .rise_o       (z_rise),
    .fall_o       (z_fall),
    .inject_cnt_o (z_cnt)
  );

  typedef struct packed {
    logic [W-1:0] sync;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic [15:0]  cnt;
  } exp_t;

  exp_t         exp_q[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  int           cyc     = 0;
  int           chg_cyc[W];
  bit           lat_en  = 1'b0;
  logic [W-1:0] prev_sync = '0;
  logic [W-1:0] masks[NRand];
  logic [15:0]  cnt_run1;

  // Behavioural reference state
  logic [W-1:0] m_st[S];
  logic [W-1:0] m_held, m_last;
  logic [15:0]  m_cnt;
  logic [31:0]  m_lfsr;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", tag, cyc, act, exp);
    end
  endtask

  task automatic model_edge();
    logic         any;
    logic [W-1:0] st0_new;
    exp_t         e;
    if (rst) begin
      for (int s = 0; s < S; s++) m_st[s] = '0;
      m_held = '0;
      m_last = '0;
      m_cnt  = '0;
      m_lfsr = 32'hC0FFEE01;
    end else begin
      any     = 1'b0;
      st0_new = '0;
      for (int i = 0; i < W; i++) begin
        logic wants, hit;
        wants = (async_i[i] != m_st[0][i]) && !m_held[i];
        case (mode)
          2'b01:   hit = wants && m_lfsr[i];
          2'b10:   hit = wants;
          default: hit = 1'b0;
        endcase
        st0_new[i] = hit ? m_st[0][i] : async_i[i];
        m_held[i]  = hit;
        any        = any | hit;
      end
      m_last = m_st[S-1];
      for (int s = S - 1; s > 0; s--) m_st[s] = m_st[s-1];
      m_st[0] = st0_new;
      if (clr) m_cnt = '0;
      else if (any && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 32'h80200003) : (m_lfsr >> 1);
    end
    e.sync = m_st[S-1];
    e.rise = m_st[S-1] & ~m_last;
    e.fall = ~m_st[S-1] & m_last;
    e.cnt  = m_cnt;
    exp_q.push_back(e);
  endtask

  task automatic set_async(input logic [W-1:0] v);
    for (int i = 0; i < W; i++) if (v[i] != async_i[i]) chg_cyc[i] = cyc;
    async_i = v;
  endtask

  task automatic tick();
    exp_t e;
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    e = exp_q.pop_front();
    check("sync", 32'(sync_o), 32'(e.sync));
    check("rise", 32'(rise_o), 32'(e.rise));
    check("fall", 32'(fall_o), 32'(e.fall));
    check("cnt", 32'(cnt_o), 32'(e.cnt));
    if (lat_en) begin
      for (int i = 0; i < W; i++) begin
        if (sync_o[i] != prev_sync[i]) begin
          check("edge_lat_2_or_3",
                32'((cyc - chg_cyc[i] == 2) || (cyc - chg_cyc[i] == 3)), 32'd1);
        end
      end
    end
    prev_sync = sync_o;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    async_i = '0;
    z_async = '0;
    mode    = 2'b00;
    clr     = 1'b0;
    for (int i = 0; i < W; i++) chg_cyc[i] = 0;

    // Reset state and zero-seed promotion
    tick();
    tick();
    check("rst_sync", 32'(sync_o), 32'd0);
    check("rst_cnt", 32'(cnt_o), 32'd0);
    check("seed0_lfsr", dut_z.lfsr_q, 32'h0000_0001);
    rst = 1'b0;
    tick();
    check("seed0_adv", dut_z.lfsr_q, 32'h8020_0003);
    check("release_no_rise", 32'(rise_o), 32'd0);
    tick();

    // No injection: latency STAGES
    set_async(8'h01);
    tick();
    check("m00_lat1", 32'(sync_o), 32'h00);
    tick();
    check("m00_sync", 32'(sync_o), 32'h01);
    check("m00_rise", 32'(rise_o), 32'h01);
    tick();
    check("m00_rise_gone", 32'(rise_o), 32'h00);
    check("m00_cnt", 32'(cnt_o), 32'd0);

    // Forced injection: latency STAGES+1, exactly one delay
    set_async(8'h00);
    repeat (4) tick();
    mode = 2'b10;
    set_async(8'h01);
    tick();
    check("m10_lat1", 32'(sync_o), 32'h00);
    tick();
    check("m10_lat2", 32'(sync_o), 32'h00);
    tick();
    check("m10_sync", 32'(sync_o), 32'h01);
    check("m10_rise", 32'(rise_o), 32'h01);
    check("m10_cnt", 32'(cnt_o), 32'd1);
    tick();
    check("m10_cnt_hold", 32'(cnt_o), 32'd1);
    mode = 2'b00;

    // Random-delay mode, run twice from reset for reproducibility
    for (int k = 0; k < NRand; k++) masks[k] = W'($urandom_range(1, 255));
    for (int run = 0; run < 2; run++) begin
      mode = 2'b00;
      set_async('0);
      do_reset();
      prev_sync = sync_o;
      mode   = 2'b01;
      lat_en = 1'b1;
      for (int k = 0; k < NRand; k++) begin
        set_async(async_i ^ masks[k]);
        repeat (4) tick();
      end
      lat_en = 1'b0;
      if (run == 0) begin
        cnt_run1 = cnt_o;
        check("rand_some_inject", 32'(cnt_o != 16'd0), 32'd1);
      end else begin
        check("rand_repro", 32'(cnt_o), 32'(cnt_run1));
      end
    end

    // Reset mid-flight with injections pending
    mode = 2'b00;
    set_async(8'hFF);
    repeat (3) tick();
    check("pre_rst_ff", 32'(sync_o), 32'hFF);
    mode = 2'b10;
    set_async(8'h00);
    tick();
    rst = 1'b1;
    tick();
    check("midrst_sync", 32'(sync_o), 32'h00);
    check("midrst_cnt", 32'(cnt_o), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("post_rst_no_fall", 32'(fall_o), 32'h00);
    end

    // Saturation: channels 0 and 1 alternate so one injection lands every cycle
    mode = 2'b10;
    for (int n = 0; n < 65600; n++) begin
      set_async(async_i ^ ((n % 2 == 0) ? 8'h01 : 8'h02));
      tick();
    end
    check("sat_cnt", 32'(cnt_o), 32'h0000_FFFF);
    clr = 1'b1;
    set_async(async_i ^ 8'h01);
    tick();
    check("clr_wins", 32'(cnt_o), 32'd0);
    clr = 1'b0;
    set_async(async_i ^ 8'h02);
    tick();
    check("count_after_clr", 32'(cnt_o), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rad_cdc_meta_sync.md
RAD_CDC_META_SYNC -- requirements
Module: rad_cdc_meta_sync

Interface
REQ-001 Parameter WIDTH, default 1; number of independent single-bit channels synchronised, legal range 1..32.
REQ-002 Parameter STAGES, default 2; flops per channel chain, legal range 2..4.
REQ-003 Parameter SEED, default 32'hC0FFEE01; LFSR reset value, and a value of 0 SHALL be replaced by 32'h00000001.
REQ-004 Port clk input 1; single clock, the destination domain.
REQ-005 Port rst input 1; synchronous, active-high reset.
REQ-006 Port async_i input WIDTH; asynchronous source bits.
REQ-007 Port inject_mode_i input 2; 00 off, 01 random delay, 10 forced delay, 11 treated as off.
REQ-008 Port cnt_clr_i input 1; synchronous clear of the injection counter.
REQ-009 Port sync_o output WIDTH; synchronised value, equal to the last chain stage.
REQ-010 Port rise_o output WIDTH; one-cycle pulse per channel on a 0->1 change of sync_o.
REQ-011 Port fall_o output WIDTH; one-cycle pulse per channel on a 1->0 change of sync_o.
REQ-012 Port inject_cnt_o output 16; saturating count of cycles in which at least one injection occurred.

Function
REQ-013 Each channel SHALL be a STAGES-deep flop chain; stage 0 samples async_i, and each subsequent stage copies the previous one every cycle.
REQ-014 A 32-bit Galois LFSR with polynomial x^32+x^22+x^2+x+1 SHALL advance once per clk cycle whenever rst is low.
REQ-015 A channel i is a candidate when async_i[i] differs from stage0[i] and held[i] is 0.
REQ-016 Injection decision per candidate: mode 01 uses lfsr[i]; mode 10 is always inject; modes 00/11 never inject.
REQ-017 An injected channel SHALL keep its old stage0 value for that cycle and set held[i]=1; otherwise stage0 loads async_i[i].
REQ-018 held[i] SHALL clear on the following cycle, so a channel is never delayed twice in a row and extra latency is at most 1 cycle.
REQ-019 Latency from a stable async_i change to sync_o SHALL be STAGES cycles with no injection and STAGES+1 cycles with injection.
REQ-020 rise_o/fall_o SHALL be combinational from sync_o and a registered copy sync_d; they are asserted in the same cycle that sync_o first shows the new value.
REQ-021 inject_cnt_o SHALL increment by 1 per cycle in which any channel injects, regardless of how many channels inject.
REQ-022 inject_cnt_o SHALL saturate at 16'hFFFF.
REQ-023 cnt_clr_i SHALL set the count to 0 and SHALL win over a simultaneous increment.
REQ-024 inject_mode_i SHALL be sampled every cycle, so a mode change affects the decision in the same cycle.
REQ-025 An input pulse shorter than one clk period MAY be lost; the block SHALL NOT stretch pulses.

Reset
REQ-026 While rst=1 at a clk edge, the following SHALL be loaded on that edge:
- all chain stages, sync_d and held cleared to 0;
- inject_cnt_o set to 0;
- LFSR loaded with SEED (or 1 if SEED is 0).
REQ-027 From the cycle after a reset edge, sync_o, rise_o and fall_o SHALL be 0.
REQ-028 No rise/fall pulse SHALL be generated for the reset-release transition itself.
REQ-029 Reset asserted mid-operation SHALL discard in-flight chain contents and held flags; the count SHALL NOT survive reset.

Verification
REQ-030 Scenario: WIDTH=1, STAGES=2, mode 00, async_i 0->1 at cycle 10 -> sync_o=1 and rise_o=1 at cycle 12, rise_o=0 at cycle 13, inject_cnt_o=0.
REQ-031 Scenario: mode 10, async_i 0->1 at cycle 10 -> sync_o rises at cycle 13, inject_cnt_o=1, held forbids a second delay.
REQ-032 Scenario: WIDTH=8, mode 01, SEED default, 1000 random toggles -> each edge latency is 2 or 3 cycles, count equals the reference-model injection count, and the result is reproducible for the same seed.
REQ-033 Scenario: mode 10, toggle every 4 cycles for 300000 cycles -> inject_cnt_o saturates at 16'hFFFF; cnt_clr_i pulsed together with an injection -> count=0.
REQ-034 Scenario: rst asserted while sync_o=8'hFF and an injection is pending -> sync_o=0, count=0, and no fall_o pulse follows reset release.
REQ-035 Scenario: SEED=0 -> LFSR equals 32'h1 after reset and advances to a nonzero value.
